hack_ram_arbiter: RTL and testbench

Two-port arbiter that shares the single RAM16K data port between the CPU data bus (port A) and a secondary bus master (port B: loader/DMA/debug host).
- Port A has fixed priority.
- Port B is protected from starvation by a bounded-wait counter that forces one B grant.
- Read data is returned to the requesting port after the RAM's fixed read latency, tagged by owner.
- Sits between CPU/host and RAM16K inside Computer.

---
 rtl/hack_mem_pkg.sv | 25 ++
 rtl/hack_rd_tag_pipe.sv | 39 +++
 rtl/hack_ram_arbiter.sv | 125 ++++++++++++
 tb/tb_hack_ram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared types for the RAM16K sharing logic: owner tags, arbiter states and
// the read-tag record carried alongside an outstanding RAM read.
package hack_mem_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  typedef enum logic {
    ARB_NORMAL  = 1'b0,
    ARB_FORCE_B = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_NONE = '{valid: 1'b0, owner: OWN_A};

endpackage

// File: rtl/hack_rd_tag_pipe.sv
// Fixed-depth shift register of read tags, matching the RAM read latency so
// the oldest tag lines up with the data appearing on ram_out.
module hack_rd_tag_pipe
  import hack_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [RD_LAT];
  rd_tag_t pipe_d [RD_LAT];

  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Reset wipes in-flight tags so a read issued before reset never returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= RD_TAG_NONE;
      end
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/hack_ram_arbiter.sv
// Shares the RAM16K port between the CPU data bus (A, fixed priority) and a
// secondary master (B) that gets a forced grant after a bounded wait.
module hack_ram_arbiter
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W   = HACK_ADDR_W,
  parameter int DATA_W   = HACK_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              arb_state
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              gnt_a, gnt_b;
  rd_tag_t           tag_in, tag_out;

  // Grants are masked while reset is low so nothing reaches the RAM.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset) begin
      if (state_q == ARB_FORCE_B && b_valid) gnt_b = 1'b1;
      else if (a_valid)                      gnt_a = 1'b1;
      else if (b_valid)                      gnt_b = 1'b1;
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (gnt_a) begin
      ram_address = a_addr;
      ram_in      = a_wdata;
      ram_load    = a_we;
    end else if (gnt_b) begin
      ram_address = b_addr;
      ram_in      = b_wdata;
      ram_load    = b_we;
    end
  end

  always_comb begin
    tag_in.valid = (gnt_a && !a_we) || (gnt_b && !b_we);
    tag_in.owner = gnt_b ? OWN_B : OWN_A;
  end

  hack_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign a_rvalid  = tag_out.valid && (tag_out.owner == OWN_A);
  assign b_rvalid  = tag_out.valid && (tag_out.owner == OWN_B);
  assign a_rdata_d = a_rvalid ? ram_out : a_rdata_q;
  assign b_rdata_d = b_rvalid ? ram_out : b_rdata_q;
  assign a_rdata   = a_rdata_d;
  assign b_rdata   = b_rdata_d;

  always_comb begin
    wait_cnt_d = 8'd0;
    if (b_valid && !gnt_b) begin
      wait_cnt_d = (wait_cnt_q >= MAX_W8) ? MAX_W8 : wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_NORMAL:  if (wait_cnt_q == MAX_W8) state_d = ARB_FORCE_B;
      ARB_FORCE_B: if (!b_valid || gnt_b)    state_d = ARB_NORMAL;
      default:                               state_d = ARB_NORMAL;
    endcase
  end

  assign arb_state = (state_q == ARB_FORCE_B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_NORMAL;
      wait_cnt_q <= 8'd0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter with a write-first, one-cycle-latency
// RAM16K model hanging off the RAM port.
module tb_hack_ram_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 1;
  localparam int MAX_WAIT = 8;

  logic              clk;
  logic              reset;
  logic              a_valid, a_we, a_ready, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_valid, b_we, b_ready, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in, ram_out;
  logic              ram_load;
  logic              arb_state;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  hack_ram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_valid     (a_valid),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_ready     (a_ready),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_valid     (b_valid),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_ready     (b_ready),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out),
    .arb_state   (arb_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM16K model: write-first, data valid one cycle after the address.
  always_ff @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
    ram_out <= ram_load ? ram_in : mem[ram_address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset   = 1'b0;
    a_valid = 1'b1;
    a_we    = 1'b1;
    a_addr  = 15'd3;
    a_wdata = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_load !== 1'b0) begin
      errors++; $display("FAIL reset_ram_load: got %b required 0", ram_load);
    end
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b required 0 0", a_ready, b_ready);
    end
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || arb_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got a_rvalid=%b b_rvalid=%b arb_state=%b required 0 0 0",
               a_rvalid, b_rvalid, arb_state);
    end
    checks++;
    if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_rdata: got a=%h b=%h required 0000 0000", a_rdata, b_rdata);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_address !== 15'd0 || ram_in !== 16'd0 || ram_load !== 1'b0) begin
      errors++;
      $display("FAIL idle_ram_port: got addr=%h in=%h load=%b required 0 0 0",
               ram_address, ram_in, ram_load);
    end
    step();
  endtask

  task automatic test_write_read();
    a_valid = 1'b1; a_we = 1'b1; a_addr = 15'd5; a_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || ram_load !== 1'b1 || ram_address !== 15'd5 || ram_in !== 16'h1234) begin
      errors++;
      $display("FAIL wr_cycle: got ready=%b load=%b addr=%h in=%h required 1 1 0005 1234",
               a_ready, ram_load, ram_address, ram_in);
    end
    step();
    a_we = 1'b0; a_wdata = 16'h0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || ram_load !== 1'b0 || a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_cycle: got ready=%b load=%b rvalid=%b required 1 0 0",
               a_ready, ram_load, a_rvalid);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234 || b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp: got a_rvalid=%b a_rdata=%h b_rvalid=%b required 1 1234 0",
               a_rvalid, a_rdata, b_rvalid);
    end
    step();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL rd_hold: got a_rvalid=%b a_rdata=%h required 0 1234", a_rvalid, a_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic exp_f;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 15'd5;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 15'd5;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_f = (c == 9) || (c == 19);
      checks++;
      if (a_ready !== !exp_f || b_ready !== exp_f || arb_state !== exp_f) begin
        errors++;
        $display("FAIL starve_c%0d: got a_ready=%b b_ready=%b arb_state=%b required %b %b %b",
                 c, a_ready, b_ready, arb_state, !exp_f, exp_f, exp_f);
      end
      step();
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_alternating();
    logic [15:0] pat [3];
    pat[0] = 16'hAAAA; pat[1] = 16'hBBBB; pat[2] = 16'hCCCC;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_we = 1'b1; a_addr = 15'(10 * (i + 1)); a_wdata = pat[i];
      step();
    end
    idle_inputs();
    a_valid = 1'b1; a_addr = 15'd10;
    step();
    idle_inputs();
    b_valid = 1'b1; b_addr = 15'd20;
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== 16'hAAAA || b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL alt_r0: got b_ready=%b a_rvalid=%b a_rdata=%h b_rvalid=%b required 1 1 aaaa 0",
               b_ready, a_rvalid, a_rdata, b_rvalid);
    end
    step();
    idle_inputs();
    a_valid = 1'b1; a_addr = 15'd30;
    @(negedge clk);
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'hBBBB || a_rvalid !== 1'b0 || a_rdata !== 16'hAAAA) begin
      errors++;
      $display("FAIL alt_r1: got b_rvalid=%b b_rdata=%h a_rvalid=%b a_rdata=%h required 1 bbbb 0 aaaa",
               b_rvalid, b_rdata, a_rvalid, a_rdata);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'hCCCC || b_rvalid !== 1'b0 || b_rdata !== 16'hBBBB) begin
      errors++;
      $display("FAIL alt_r2: got a_rvalid=%b a_rdata=%h b_rvalid=%b b_rdata=%h required 1 cccc 0 bbbb",
               a_rvalid, a_rdata, b_rvalid, b_rdata);
    end
    step();
  endtask

  task automatic test_b_withdraw();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 15'd10;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 15'd20;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b1 || arb_state !== 1'b0) begin
        errors++;
        $display("FAIL wd_wait_c%0d: got a_ready=%b arb_state=%b required 1 0", c, a_ready, arb_state);
      end
      step();
    end
    b_valid = 1'b0;
    step();
    b_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0 || arb_state !== 1'b0) begin
        errors++;
        $display("FAIL wd_again_c%0d: got a_ready=%b b_ready=%b arb_state=%b required 1 0 0",
                 c, a_ready, b_ready, arb_state);
      end
      step();
    end
    b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (arb_state !== 1'b1 || a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL force_withdraw: got arb_state=%b a_ready=%b b_ready=%b required 1 1 0",
               arb_state, a_ready, b_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (arb_state !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL force_exit: got arb_state=%b a_ready=%b required 0 1", arb_state, a_ready);
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset_inflight();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 15'd30;
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 16'h0) begin
      errors++;
      $display("FAIL inflight_in_reset: got a_rvalid=%b b_rvalid=%b a_rdata=%h required 0 0 0000",
               a_rvalid, b_rvalid, a_rdata);
    end
    step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 16'h0) begin
        errors++;
        $display("FAIL inflight_after_c%0d: got a_rvalid=%b b_rvalid=%b a_rdata=%h required 0 0 0000",
                 c, a_rvalid, b_rvalid, a_rdata);
      end
      step();
    end
    b_valid = 1'b1; b_we = 1'b0; b_addr = 15'd20;
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1 || ram_address !== 15'd20) begin
      errors++;
      $display("FAIL post_reset_grant: got b_ready=%b addr=%h required 1 0014", b_ready, ram_address);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'hBBBB) begin
      errors++;
      $display("FAIL post_reset_read: got b_rvalid=%b b_rdata=%h required 1 bbbb", b_rvalid, b_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_starvation();
    test_alternating();
    test_b_withdraw();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
